// File: rtl/gcd_seq.sv
// ---------------------------------------------------------------------------
// gcd_seq
//   Upstream sequencer for a subtractive gcd_rtl core. Takes one operand pair
//   at a time over a valid/ready handshake, loads it into the core (start=0),
//   lets the core run (start=1) until it raises rdy, and hands the result
//   downstream over a valid/ready handshake. Operands with their MSB set are
//   rejected without running the core. A watchdog aborts a job whose run
//   phase lasts TimeoutCyc cycles.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only while idle)
//   in_x, in_y          operands, unsigned, MSB must be 0
//   out_valid/out_ready result handshake; result held while stalled
//   out_gcd, out_err    result (0 on error) and error flag
//   core_xi/yi/start/rst  drive the gcd_rtl core
//   core_rdy, core_xo     status and result from the gcd_rtl core
//   busy                high whenever a job is in flight or waiting to drain
//   job_cnt             completed jobs (ok and error), wraps
//
// Every output is a flop. The next value of each is derived from the next
// state, so nothing from in_* or core_rdy reaches an output in the same cycle.
// ---------------------------------------------------------------------------
module gcd_seq #(
    parameter int unsigned NBits      = 8,
    parameter int unsigned TimeoutCyc = 300,
    parameter int unsigned CntW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [NBits-1:0] in_x,
    input  logic [NBits-1:0] in_y,
    output logic             in_ready,
    output logic             out_valid,
    output logic [NBits-1:0] out_gcd,
    output logic             out_err,
    input  logic             out_ready,
    output logic [NBits-1:0] core_xi,
    output logic [NBits-1:0] core_yi,
    output logic             core_start,
    output logic             core_rst,
    input  logic             core_rdy,
    input  logic [NBits-1:0] core_xo,
    output logic             busy,
    output logic [CntW-1:0]  job_cnt
);

    // Last watchdog count value allowed in RUN before the job is aborted.
    localparam logic [CntW-1:0] TIMEOUT_LAST = CntW'(TimeoutCyc - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_reg,      state_next;
    logic [NBits-1:0] op_x_reg,       op_x_next;
    logic [NBits-1:0] op_y_reg,       op_y_next;
    logic [CntW-1:0]  cnt_reg,        cnt_next;
    logic [NBits-1:0] out_gcd_reg,    out_gcd_next;
    logic             out_err_reg,    out_err_next;
    logic [CntW-1:0]  job_cnt_reg,    job_cnt_next;
    logic             out_valid_reg,  out_valid_next;
    logic             in_ready_reg,   in_ready_next;
    logic             busy_reg,       busy_next;
    logic             core_start_reg, core_start_next;
    logic             core_rst_reg,   core_rst_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            op_x_reg       <= '0;
            op_y_reg       <= '0;
            cnt_reg        <= '0;
            out_gcd_reg    <= '0;
            out_err_reg    <= 1'b0;
            job_cnt_reg    <= '0;
            out_valid_reg  <= 1'b0;
            in_ready_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            core_start_reg <= 1'b0;
            core_rst_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            op_x_reg       <= op_x_next;
            op_y_reg       <= op_y_next;
            cnt_reg        <= cnt_next;
            out_gcd_reg    <= out_gcd_next;
            out_err_reg    <= out_err_next;
            job_cnt_reg    <= job_cnt_next;
            out_valid_reg  <= out_valid_next;
            in_ready_reg   <= in_ready_next;
            busy_reg       <= busy_next;
            core_start_reg <= core_start_next;
            core_rst_reg   <= core_rst_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_x_next    = op_x_reg;
        op_y_next    = op_y_reg;
        cnt_next     = cnt_reg;
        out_gcd_next = out_gcd_reg;
        out_err_next = out_err_reg;
        job_cnt_next = job_cnt_reg;

        unique case (state_reg)
            IDLE: begin
                // in_ready is high exactly in IDLE, so in_valid alone is the handshake.
                if (in_valid) begin
                    op_x_next = in_x;
                    op_y_next = in_y;
                    if (in_x[NBits-1] || in_y[NBits-1]) begin
                        // The core would see a negative operand: skip it entirely.
                        state_next   = DONE;
                        out_gcd_next = '0;
                        out_err_next = 1'b1;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                state_next = RUN;
                cnt_next   = '0;
            end
            RUN: begin
                // rdy is checked first so a result on the last allowed cycle is kept.
                if (core_rdy) begin
                    state_next   = DONE;
                    out_gcd_next = core_xo;
                    out_err_next = 1'b0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next   = DONE;
                    out_gcd_next = '0;
                    out_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next   = IDLE;
                    job_cnt_next = job_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Registered outputs follow the state being entered.
        out_valid_next  = (state_next == DONE);
        in_ready_next   = (state_next == IDLE);
        busy_next       = (state_next != IDLE);
        core_start_next = (state_next == RUN);
        // Core held in reset while idle or draining, which also drops its rdy.
        core_rst_next   = (state_next == IDLE) || (state_next == DONE);
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign out_gcd    = out_gcd_reg;
    assign out_err    = out_err_reg;
    assign core_xi    = op_x_reg;
    assign core_yi    = op_y_reg;
    assign core_start = core_start_reg;
    assign core_rst   = core_rst_reg;
    assign busy       = busy_reg;
    assign job_cnt    = job_cnt_reg;

endmodule
